// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame into 32-bit words written to instruction memory.
// Latency: each word's write strobe is registered one cycle after its 4th byte; done/err one cycle after the last frame byte.
// Backpressure: byte_ready is high while loading and low in DONE/ERROR until a reload re-arms the loader.
module imem_loader #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    // Widened so a 16-bit length can be compared against the capacity without truncation.
    localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [1:0]  lane;
    logic [23:0] partial;
    logic [7:0]  xor_acc;

    logic        accept;
    logic [15:0] len_full;
    logic [15:0] idx_next;

    assign accept       = byte_valid && byte_ready;
    assign len_full     = {byte_data, len_lo};
    assign idx_next     = word_idx + 16'd1;
    // The word index doubles as the count of words written so far in this load.
    assign words_loaded = word_idx;

    // Ready is decoded straight from state so a source sees it stop the moment the frame ends.
    always_comb begin
        byte_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    end

    // Frame parser, word assembler and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LEN0;
            len_lo    <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            lane      <= '0;
            partial   <= '0;
            xor_acc   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LEN0: begin
                    if (accept) begin
                        len_lo  <= byte_data;
                        xor_acc <= xor_acc ^ byte_data;
                        state   <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        word_cnt <= len_full;
                        xor_acc  <= xor_acc ^ byte_data;
                        if ({1'b0, len_full} > DEPTH_LIM) begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ byte_data;
                        lane    <= lane + 2'd1;
                        case (lane)
                            2'd0: partial[7:0]   <= byte_data;
                            2'd1: partial[15:8]  <= byte_data;
                            2'd2: partial[23:16] <= byte_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= {14'b0, word_idx, 2'b00};
                                mem_wdata <= {byte_data, partial};
                                word_idx  <= idx_next;
                                if (idx_next == word_cnt) begin
                                    state <= CSUM;
                                end
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (byte_data == xor_acc) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    // Re-arm for a fresh image; memory contents are left as they are.
                    if (reload) begin
                        state     <= LEN0;
                        word_idx  <= '0;
                        lane      <= '0;
                        xor_acc   <= '0;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                default: state <= LEN0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a queue-based model of the expected writes and final status.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    logic [63:0] wq[$];
    logic [7:0]  frame[$];
    logic [31:0] words[$];

    imem_loader #(.MEM_DEPTH(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every write strobe; a strobe alongside load_done would break the ordering guarantee.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back({mem_addr, mem_wdata});
            if (load_done === 1'b1) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) chk("ready_timeout", {63'b0, byte_ready}, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        wq.delete();
        foreach (frame[i]) send_byte(frame[i], (i == frame.size() - 1) ? 0 : gap);
    endtask

    // Model: length prefix, little-endian words, XOR over all preceding bytes.
    task automatic make_frame(input bit bad);
        logic [7:0] x;
        int n;
        n = words.size();
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        foreach (words[i]) for (int k = 0; k < 4; k++) frame.push_back(words[i][8*k +: 8]);
        x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        if (bad) x ^= 8'($urandom_range(1, 255));
        frame.push_back(x);
    endtask

    task automatic check_result(input string tag, input bit bad);
        chk({tag, "_nwrites"}, 64'(wq.size()), 64'(words.size()));
        if (wq.size() == words.size())
            foreach (words[i])
                chk($sformatf("%s_w%0d", tag, i), wq[i], {32'(i * 4), words[i]});
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'(words.size()));
        chk({tag, "_done"}, {63'b0, load_done}, bad ? 64'd0 : 64'd1);
        chk({tag, "_err"}, {63'b0, load_err}, bad ? 64'd1 : 64'd0);
        chk({tag, "_cpu_reset"}, {63'b0, cpu_reset}, bad ? 64'd1 : 64'd0);
        chk({tag, "_ready"}, {63'b0, byte_ready}, 64'd0);
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk({tag, "_rl_done"}, {63'b0, load_done}, 64'd0);
        chk({tag, "_rl_err"}, {63'b0, load_err}, 64'd0);
        chk({tag, "_rl_words"}, 64'(words_loaded), 64'd0);
        chk({tag, "_rl_cpu_reset"}, {63'b0, cpu_reset}, 64'd1);
        chk({tag, "_rl_ready"}, {63'b0, byte_ready}, 64'd1);
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload     = 1'b0;
        #12;
        chk("rst_ready", {63'b0, byte_ready}, 64'd1);
        chk("rst_cpu_reset", {63'b0, cpu_reset}, 64'd1);
        chk("rst_we", {63'b0, mem_we}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_done", {63'b0, load_done}, 64'd0);
        chk("rst_err", {63'b0, load_err}, 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Two-word image, back to back.
        words = '{32'h20080005, 32'hAC080000};
        frame = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h08, 8'hAC, 8'h8B};
        send_frame(0);
        check_result("two", 1'b0);
        do_reload("two");

        // Same image with 3-cycle gaps between bytes.
        send_frame(3);
        check_result("gap", 1'b0);

        // Bytes offered while DONE must not be consumed.
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        chk("hold_words", 64'(words_loaded), 64'd2);
        chk("hold_done", {63'b0, load_done}, 64'd1);
        chk("hold_nwrites", 64'(wq.size()), 64'd2);
        do_reload("gap");

        // Empty image.
        words.delete();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check_result("empty", 1'b0);
        do_reload("empty");

        // Length 1025 overflows a 1024-word memory.
        frame = '{8'h01, 8'h04};
        send_frame(0);
        chk("ovf_err", {63'b0, load_err}, 64'd1);
        chk("ovf_ready", {63'b0, byte_ready}, 64'd0);
        chk("ovf_cpu_reset", {63'b0, cpu_reset}, 64'd1);
        chk("ovf_done", {63'b0, load_done}, 64'd0);
        chk("ovf_nwrites", 64'(wq.size()), 64'd0);
        do_reload("ovf");

        // Bad checksum, then recovery.
        words = '{32'h20080005, 32'hAC080000};
        frame = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h08, 8'hAC, 8'h8A};
        send_frame(0);
        check_result("badcs", 1'b1);
        do_reload("badcs");
        frame[10] = 8'h8B;
        send_frame(0);
        check_result("recover", 1'b0);
        do_reload("recover");

        // Reset after six bytes, then a full resend.
        wq.delete();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        #1 reset = 1'b0;
        #1;
        chk("mid_we", {63'b0, mem_we}, 64'd0);
        chk("mid_words", 64'(words_loaded), 64'd0);
        chk("mid_ready", {63'b0, byte_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(0);
        check_result("mid", 1'b0);
        do_reload("mid");

        // Random images, some with corrupted checksums.
        for (int t = 0; t < 8; t++) begin
            bit bad;
            int n;
            n   = $urandom_range(0, 5);
            bad = ($urandom_range(0, 2) == 0);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            make_frame(bad);
            send_frame($urandom_range(0, 2));
            check_result($sformatf("rnd%0d", t), bad);
            do_reload($sformatf("rnd%0d", t));
        end

        // Largest accepted image.
        words.delete();
        for (int i = 0; i < 1024; i++) words.push_back($urandom);
        make_frame(1'b0);
        send_frame(0);
        check_result("full", 1'b0);

        chk("we_done_overlap", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of `single_cycle_cpu`. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes them sequentially into the instruction memory's write port and holds the CPU in reset until a complete, checksum-verified image is in place. It reports completion or failure and can be re-armed for a fresh load without a global reset.

## Interface
- `MEM_DEPTH`, 1024: instruction memory capacity in 32-bit words; the maximum accepted word count.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset); clears all state immediately.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle. A transfer occurs when `byte_valid && byte_ready` at the edge.
- `reload` in 1: single-cycle request to start a new load; honoured only in DONE or ERROR.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out 32: byte address of the write, equal to word index × 4.
- `mem_wdata` out 32: assembled word.
- `cpu_reset` out 1: active-high reset to the CPU. It is 1 whenever an image is not verified.
- `load_done` out 1: image loaded and checksum matched.
- `load_err` out 1: length overflow or checksum mismatch.
- `words_loaded` out 16: count of words written in the current load.

## Operation
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 data bytes, least-significant byte first per word.
  - One checksum byte.
  - Checksum = XOR of all preceding frame bytes, including the length bytes.
- FSM states: LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - Reset state: LEN0.
- LEN0: on accept, latch low length byte, go to LEN1.
- LEN1: on accept, latch high byte. Next state:
  - N > MEM_DEPTH → ERROR.
  - N = 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Byte lane counter (2 bits) selects the shift position.
  - On each 4th accepted byte, register the word, pulse `mem_we`, and increment the word index and `words_loaded`.
  - After word N, go to CSUM.
- CSUM: on accept, compare the byte with the running XOR. Match → DONE; mismatch → ERROR.
- DONE: `cpu_reset`=0, `load_done`=1.
- ERROR: `cpu_reset`=1, `load_err`=1.
- `reload` in DONE/ERROR clears the following and goes to LEN0:
  - word index, byte lane, XOR accumulator, `words_loaded`, `load_done`, `load_err`;
  - sets `cpu_reset`=1.
- `reload` in any other state is ignored.
- `byte_ready` is 1 in LEN0, LEN1, DATA, CSUM and 0 in DONE/ERROR. Bytes offered in DONE/ERROR are not consumed.
- Word index width is 16 bits. `mem_addr` = {14'b0, index, 2'b00}. The index never exceeds MEM_DEPTH−1, so no wrap occurs.
- Memory written in a failed load is not scrubbed. The CPU stays in reset.

## Timing
- Reset values:
  - `byte_ready`=1 (LEN0), `cpu_reset`=1.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `load_done`=0, `load_err`=0, `words_loaded`=0.
- All outputs are registered except `byte_ready`, which is decoded from state.
- `mem_we`, `mem_addr`, `mem_wdata` are valid the cycle after the 4th byte of a word is accepted. `mem_we` is high for exactly one cycle.
- `words_loaded` updates in the same cycle as `mem_we`.
- Throughput: one byte per cycle. `byte_valid` gaps stall without losing state.
- A write strobe for word k may coincide with acceptance of the first byte of word k+1.
- The DONE/ERROR transition and the `load_done`/`load_err`/`cpu_reset` updates occur the cycle after the checksum byte, or after LEN_HI for overflow.
- The final word's `mem_we` always precedes `load_done` by at least one cycle.
- `reload` effect is visible the next cycle.
- Asynchronous `reset` mid-frame aborts immediately: partial word discarded, `mem_we` forced 0, back to LEN0.

## Test plan
- Load two words. Bytes 02 00 05 00 08 20 00 00 08 AC 8B →
  - `mem_we` pulses with addr 0x0/data 0x20080005, then addr 0x4/data 0xAC080000;
  - `words_loaded`=2, `load_done`=1, `cpu_reset`=0.
- Repeat the same frame with `byte_valid` low for 3 cycles between every byte → identical writes and completion; no duplicated or lost bytes.
- Empty image, bytes 00 00 00 → no `mem_we`; `load_done`=1, `cpu_reset`=0.
- Overflow with MEM_DEPTH=1024, bytes 01 04 (N=1025) → ERROR next cycle: `load_err`=1, `byte_ready`=0, `cpu_reset`=1, no writes.
- Bad checksum: the two-word frame with final byte 8A →
  - both writes occur;
  - `load_err`=1, `load_done`=0, `cpu_reset`=1.
  - Then pulse `reload` and send the correct frame → `load_done`=1, `words_loaded`=2.
- Reset mid-frame: assert `reset`=0 after 6 bytes of the two-word frame, release, resend the full frame → exactly two writes at addr 0x0/0x4 and `load_done`=1.
